// File: rtl/imem_pkg.sv
// Shared definitions for the instruction-memory arbiter.
//   - imem_state_e : arbiter FSM states (idle, waiting on ROM, presenting response)
//   - REQ_FETCH / REQ_DEBUG : requester indices into the per-requester vectors
//   - addr_err()   : misalignment / out-of-range check on a byte address
package imem_pkg;

  typedef enum logic [1:0] {
    StIdle = 2'd0,
    StWait = 2'd1,
    StResp = 2'd2
  } imem_state_e;

  localparam logic REQ_FETCH = 1'b0;
  localparam logic REQ_DEBUG = 1'b1;

  // Flags a byte address that is not word aligned or that addresses beyond a ROM
  // of 2**addr_width words (any bit above the word-index field set).
  function automatic logic addr_err(input logic [31:0] addr, input int unsigned addr_width);
    logic [31:0] hi;
    hi = addr >> (addr_width + 2);
    return (addr[1:0] != 2'b00) || (hi != 32'd0);
  endfunction

endpackage

// File: rtl/rr_arbiter2.sv
// Two-input round-robin grant logic.
//   clock, reset : clock and synchronous active-high reset
//   req          : request vector (bit 0 = fetch, bit 1 = debug)
//   update       : load the current grant into the last-grant register
//   grant        : one-hot grant, zero when no request
//   grant_id     : index of the granted requester (meaningful when req != 0)
// After reset the last grant points at the debug requester, so fetch wins the
// first contested round.
module rr_arbiter2
  import imem_pkg::*;
(
  input  logic       clock,
  input  logic       reset,
  input  logic [1:0] req,
  input  logic       update,
  output logic [1:0] grant,
  output logic       grant_id
);

  logic last_q, last_d;

  always_comb begin
    grant_id = REQ_FETCH;
    grant    = 2'b00;
    case (req)
      2'b01:   grant_id = REQ_FETCH;
      2'b10:   grant_id = REQ_DEBUG;
      // Contested: hand the grant to whoever did not get it last time.
      2'b11:   grant_id = ~last_q;
      default: grant_id = REQ_FETCH;
    endcase
    if (req != 2'b00) begin
      grant = grant_id ? 2'b10 : 2'b01;
    end
    last_d = update ? grant_id : last_q;
  end

  always_ff @(posedge clock) begin
    if (reset) begin
      last_q <= REQ_DEBUG;
    end else begin
      last_q <= last_d;
    end
  end

endmodule

// File: rtl/imem_arbiter.sv
// Instruction ROM arbiter: shares one synchronous-read ROM between the core fetch
// port (requester 0) and a debug/loader reader (requester 1).
//   clock, reset          : clock; synchronous active-high reset (shared with ROM)
//   req_valid / req_ready : per-requester request handshake; ready is combinational
//   req_addr0 / req_addr1 : requester byte addresses
//   rsp_valid / rsp_ready : per-requester response handshake
//   rsp_data, rsp_err     : shared response word and error flag
//   rom_addr, rom_data    : ROM byte address out; ROM word in, one clock later
//   busy                  : transaction in flight
// One transaction at a time: grant in IDLE, capture ROM data in WAIT, hold the
// response in RESP until accepted. Accept in T gives rsp_valid in T+2.
// NUM_REQ only supports 2.
module imem_arbiter
  import imem_pkg::*;
#(
  parameter int unsigned ADDR_WIDTH = 8,
  parameter int unsigned NUM_REQ    = 2
) (
  input  logic               clock,
  input  logic               reset,
  input  logic [NUM_REQ-1:0] req_valid,
  output logic [NUM_REQ-1:0] req_ready,
  input  logic [31:0]        req_addr0,
  input  logic [31:0]        req_addr1,
  output logic [NUM_REQ-1:0] rsp_valid,
  input  logic [NUM_REQ-1:0] rsp_ready,
  output logic [31:0]        rsp_data,
  output logic               rsp_err,
  output logic [31:0]        rom_addr,
  input  logic [31:0]        rom_data,
  output logic               busy
);

  imem_state_e state_q, state_d;
  logic [31:0] addr_q, addr_d;
  logic        gnt_q, gnt_d;
  logic [31:0] data_q, data_d;
  logic        err_q, err_d;

  logic [1:0]  arb_grant;
  logic        arb_id;
  logic        accept;
  logic [31:0] sel_addr;

  rr_arbiter2 u_rr_arbiter2 (
    .clock    (clock),
    .reset    (reset),
    .req      (req_valid),
    .update   (accept),
    .grant    (arb_grant),
    .grant_id (arb_id)
  );

  assign sel_addr = arb_id ? req_addr1 : req_addr0;

  always_comb begin
    state_d   = state_q;
    addr_d    = addr_q;
    gnt_d     = gnt_q;
    data_d    = data_q;
    err_d     = err_q;
    req_ready = '0;
    rsp_valid = '0;
    accept    = 1'b0;
    // The ROM sees the registered address except in the grant cycle, so its
    // input is steady while the read completes.
    rom_addr  = addr_q;

    unique case (state_q)
      StIdle: begin
        if (|req_valid) begin
          accept    = 1'b1;
          req_ready = arb_grant;
          rom_addr  = sel_addr;
          addr_d    = sel_addr;
          gnt_d     = arb_id;
          state_d   = StWait;
        end
      end
      StWait: begin
        // Data is kept even on error: the ROM returns the aliased word.
        data_d  = rom_data;
        err_d   = addr_err(addr_q, ADDR_WIDTH);
        state_d = StResp;
      end
      StResp: begin
        rsp_valid[gnt_q] = 1'b1;
        if (rsp_ready[gnt_q]) begin
          state_d = StIdle;
        end
      end
      default: state_d = StIdle;
    endcase

    // Reset drops any pending transaction and silences both handshakes at once.
    if (reset) begin
      req_ready = '0;
      rsp_valid = '0;
      accept    = 1'b0;
      rom_addr  = addr_q;
    end
  end

  always_ff @(posedge clock) begin
    if (reset) begin
      state_q <= StIdle;
      addr_q  <= '0;
      gnt_q   <= REQ_FETCH;
      data_q  <= '0;
      err_q   <= 1'b0;
    end else begin
      state_q <= state_d;
      addr_q  <= addr_d;
      gnt_q   <= gnt_d;
      data_q  <= data_d;
      err_q   <= err_d;
    end
  end

  assign rsp_data = reset ? 32'd0 : data_q;
  assign rsp_err  = reset ? 1'b0 : err_q;
  assign busy     = (state_q != StIdle) && !reset;

endmodule

// File: tb/tb_imem_arbiter.sv
// Scoreboard bench for imem_arbiter. A transaction-level predictor decides each
// cycle whether a request is taken and by whom, checks the request side, and
// queues the expected response; a monitor checks every response the DUT shows.
module tb_imem_arbiter;

  localparam int unsigned AW        = 8;
  localparam int unsigned ROM_WORDS = 1 << AW;

  logic        clock = 1'b0;
  logic        reset;
  logic [1:0]  req_valid;
  logic [1:0]  req_ready;
  logic [31:0] req_addr0;
  logic [31:0] req_addr1;
  logic [1:0]  rsp_valid;
  logic [1:0]  rsp_ready;
  logic [31:0] rsp_data;
  logic        rsp_err;
  logic [31:0] rom_addr;
  logic [31:0] rom_data;
  logic        busy;

  imem_arbiter #(
    .ADDR_WIDTH (AW),
    .NUM_REQ    (2)
  ) dut (
    .clock     (clock),
    .reset     (reset),
    .req_valid (req_valid),
    .req_ready (req_ready),
    .req_addr0 (req_addr0),
    .req_addr1 (req_addr1),
    .rsp_valid (rsp_valid),
    .rsp_ready (rsp_ready),
    .rsp_data  (rsp_data),
    .rsp_err   (rsp_err),
    .rom_addr  (rom_addr),
    .rom_data  (rom_data),
    .busy      (busy)
  );

  always #5 clock = ~clock;

  // Synchronous-read ROM: word index taken from the low address bits (aliasing).
  logic [31:0] rom_mem [ROM_WORDS];
  always @(posedge clock) rom_data <= rom_mem[rom_addr[AW+1:2]];

  int unsigned cyc = 0;
  always @(posedge clock) cyc <= cyc + 1;

  int checks   = 0;
  int failures = 0;

  task automatic chk(input string name, input logic [31:0] act, input logic [31:0] exp);
    checks++;
    if (act !== exp) begin
      failures++;
      $display("FAIL %s: got 0x%0h, expected 0x%0h (cycle %0d)", name, act, exp, cyc);
    end
  endtask

  typedef struct {
    logic [1:0]  onehot;
    logic [31:0] data;
    logic        err;
    int unsigned due;
  } exp_t;

  exp_t        sb_q[$];
  int unsigned grant_log[$];

  // Predictor state: phase 0 = free, 1 = ROM read pending, 2 = response pending.
  int unsigned m_phase     = 0;
  int unsigned m_last      = 1;
  int unsigned m_id        = 0;
  logic [31:0] m_last_addr = 32'd0;

  always @(negedge clock) begin : predictor
    logic [1:0]  exp_ready;
    logic [31:0] exp_rom;
    int unsigned g;
    exp_t        e;
    exp_ready = 2'b00;
    exp_rom   = m_last_addr;
    g         = 0;
    if (!reset && m_phase == 0 && req_valid != 2'b00) begin
      if (req_valid == 2'b11) g = (m_last == 1) ? 0 : 1;
      else                    g = req_valid[1] ? 1 : 0;
      exp_ready[g] = 1'b1;
      exp_rom      = (g == 1) ? req_addr1 : req_addr0;
    end
    if (cyc >= 1) begin
      chk("req_ready", {30'd0, req_ready}, {30'd0, exp_ready});
      chk("rom_addr", rom_addr, exp_rom);
      chk("busy", {31'd0, busy}, {31'd0, (!reset && m_phase != 0)});
    end
    if (reset) begin
      m_phase     = 0;
      m_last      = 1;
      m_last_addr = 32'd0;
      sb_q.delete();
    end else begin
      case (m_phase)
        0: if (exp_ready != 2'b00) begin
          e.onehot = exp_ready;
          e.data   = rom_mem[(exp_rom >> 2) % ROM_WORDS];
          e.err    = (exp_rom % 4 != 0) || (exp_rom >= ROM_WORDS * 4);
          e.due    = cyc + 2;
          sb_q.push_back(e);
          grant_log.push_back(g);
          m_last      = g;
          m_id        = g;
          m_last_addr = exp_rom;
          m_phase     = 1;
        end
        1: m_phase = 2;
        default: if (rsp_ready[m_id]) m_phase = 0;
      endcase
    end
  end

  int          hs_count     = 0;
  logic [31:0] last_hs_data = 32'd0;
  logic        last_hs_err  = 1'b0;

  always @(negedge clock) begin : monitor
    if (cyc >= 1) begin
      if (reset) begin
        chk("reset_rsp_valid", {30'd0, rsp_valid}, 32'd0);
        chk("reset_rsp_data", rsp_data, 32'd0);
        chk("reset_rsp_err", {31'd0, rsp_err}, 32'd0);
      end else if (sb_q.size() > 0 && cyc >= sb_q[0].due) begin
        chk("rsp_valid", {30'd0, rsp_valid}, {30'd0, sb_q[0].onehot});
        chk("rsp_data", rsp_data, sb_q[0].data);
        chk("rsp_err", {31'd0, rsp_err}, {31'd0, sb_q[0].err});
        if ((rsp_valid & rsp_ready) != 2'b00) begin
          hs_count++;
          last_hs_data = rsp_data;
          last_hs_err  = rsp_err;
          void'(sb_q.pop_front());
        end
      end else begin
        chk("rsp_unexpected", {30'd0, rsp_valid}, 32'd0);
      end
    end
  end

  task automatic step(input int n);
    repeat (n) begin
      @(posedge clock);
      #1;
    end
  endtask

  task automatic do_reset();
    reset = 1'b1;
    step(2);
    reset = 1'b0;
  endtask

  function automatic logic [31:0] rand_addr();
    case ($urandom_range(0, 3))
      0:       return ($urandom % ROM_WORDS) * 4;
      1:       return ($urandom % (ROM_WORDS * 4)) | 32'h1;
      2:       return ($urandom | (ROM_WORDS * 4)) & ~32'h3;
      default: return $urandom;
    endcase
  endfunction

  int hs0;
  int nlog;

  initial begin
    for (int i = 0; i < ROM_WORDS; i++) rom_mem[i] = $urandom;
    reset     = 1'b1;
    req_valid = 2'b00;
    rsp_ready = 2'b00;
    req_addr0 = 32'd0;
    req_addr1 = 32'd0;
    step(3);
    reset = 1'b0;

    // Single fetch read of word 4.
    rsp_ready = 2'b11;
    req_valid = 2'b01;
    req_addr0 = 32'h10;
    step(1);
    req_valid = 2'b00;
    step(4);
    chk("first_rsp_data", last_hs_data, rom_mem[4]);
    chk("first_rsp_err", {31'd0, last_hs_err}, 32'd0);

    // Continuous contention from reset: grants alternate starting with fetch.
    do_reset();
    grant_log.delete();
    req_valid = 2'b11;
    req_addr0 = 32'h20;
    req_addr1 = 32'h44;
    step(12);
    req_valid = 2'b00;
    step(3);
    chk("rr_count", grant_log.size(), 4);
    if (grant_log.size() == 4) begin
      for (int i = 0; i < 4; i++) chk("rr_order", grant_log[i], i % 2);
    end

    // Response stalled 5 cycles with both requesters pushing: one handshake only.
    rsp_ready = 2'b00;
    req_valid = 2'b01;
    req_addr0 = 32'h30;
    hs0       = hs_count;
    step(1);
    req_valid = 2'b11;
    step(1);
    step(5);
    rsp_ready = 2'b11;
    step(1);
    req_valid = 2'b00;
    step(4);
    chk("stall_single_handshake", hs_count - hs0, 1);

    // Out-of-range debug read: error flagged, aliased word 0 returned.
    req_valid = 2'b10;
    req_addr1 = 32'h402;
    step(1);
    req_valid = 2'b00;
    step(4);
    chk("oor_rsp_err", {31'd0, last_hs_err}, 32'd1);
    chk("oor_rsp_data", last_hs_data, rom_mem[0]);

    // Reset while the ROM read is pending: transaction vanishes, fetch wins next.
    hs0       = hs_count;
    req_valid = 2'b01;
    req_addr0 = 32'h8;
    step(1);
    req_valid = 2'b00;
    reset     = 1'b1;
    step(1);
    reset = 1'b0;
    step(3);
    chk("dropped_no_handshake", hs_count - hs0, 0);
    nlog      = grant_log.size();
    req_valid = 2'b11;
    step(1);
    req_valid = 2'b00;
    step(4);
    chk("post_reset_grant_count", grant_log.size() - nlog, 1);
    if (grant_log.size() > 0) chk("post_reset_grant", grant_log[$], 0);
    chk("post_reset_handshake", hs_count - hs0, 1);

    // Randomized traffic with occasional resets.
    for (int i = 0; i < 600; i++) begin
      reset     = ($urandom_range(0, 149) == 0);
      req_valid = 2'($urandom);
      req_addr0 = rand_addr();
      req_addr1 = rand_addr();
      rsp_ready = {($urandom_range(0, 3) != 0), ($urandom_range(0, 3) != 0)};
      step(1);
    end
    reset     = 1'b0;
    req_valid = 2'b00;
    rsp_ready = 2'b11;
    step(6);
    chk("scoreboard_drained", sb_q.size(), 0);

    $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
    $finish;
  end

endmodule
